// File: rtl/simple_system_dmem_arb.sv
// rtl/simple_system_dmem_arb.sv - two-host arbiter for the simple-system data memory port
// Optional feature macro: SIMPLE_SYSTEM_DMEM_ARB_RR_EN (round-robin on contention;
// fixed priority to host 0 when undefined).
// Responses are routed back to the issuing host via an in-order ID FIFO.

module simple_system_dmem_arb #(
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,

  input  logic        h0_req_i,
  output logic        h0_gnt_o,
  input  logic        h0_we_i,
  input  logic [31:0] h0_addr_i,
  input  logic [3:0]  h0_be_i,
  input  logic [31:0] h0_wdata_i,
  output logic        h0_rvalid_o,
  output logic [31:0] h0_rdata_o,
  output logic        h0_err_o,

  input  logic        h1_req_i,
  output logic        h1_gnt_o,
  input  logic        h1_we_i,
  input  logic [31:0] h1_addr_i,
  input  logic [3:0]  h1_be_i,
  input  logic [31:0] h1_wdata_i,
  output logic        h1_rvalid_o,
  output logic [31:0] h1_rdata_o,
  output logic        h1_err_o,

  output logic        dev_req_o,
  input  logic        dev_gnt_i,
  output logic        dev_we_o,
  output logic [31:0] dev_addr_o,
  output logic [3:0]  dev_be_o,
  output logic [31:0] dev_wdata_o,
  input  logic        dev_rvalid_i,
  input  logic [31:0] dev_rdata_i,
  input  logic        dev_err_i,

  output logic        unexpected_rvalid_o
);

  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam logic [CntW-1:0] CntMax  = CntW'(MaxOutstanding);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(MaxOutstanding - 1);

  // Outstanding-transaction bookkeeping
  logic [CntW-1:0]           r_count;
  logic [PtrW-1:0]           r_wptr;
  logic [PtrW-1:0]           r_rptr;
  logic [MaxOutstanding-1:0] r_ids;
  logic                      r_unexpected;

  logic w_any_req;
  logic w_sel;
  logic w_full;
  logic w_dev_req;
  logic w_push;
  logic w_pop;
  logic w_head;

  // Pointers wrap at the FIFO depth, which need not be a power of two
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    return (ptr == PtrLast) ? '0 : ptr + PtrW'(1);
  endfunction

  assign w_any_req = h0_req_i | h1_req_i;

`ifdef SIMPLE_SYSTEM_DMEM_ARB_RR_EN
  logic r_last_granted;

  // Contention goes to the host that was not granted last; reset value 1 favours host 0 first
  always_comb begin
    w_sel = 1'b0;
    if (h0_req_i && h1_req_i) begin
      w_sel = ~r_last_granted;
    end else begin
      w_sel = h1_req_i;
    end
  end

  // Remember which host won the most recent handshake
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_last_granted <= 1'b1;
    end else if (w_push) begin
      r_last_granted <= w_sel;
    end
  end
`else
  // Fixed priority: host 1 is selected only when host 0 is idle
  always_comb begin
    w_sel = 1'b0;
    w_sel = h1_req_i & ~h0_req_i;
  end
`endif

  // full comes from the registered count, so a same-cycle pop never enables a push at full
  assign w_full    = (r_count == CntMax);
  assign w_dev_req = w_any_req & ~w_full;
  assign w_push    = w_dev_req & dev_gnt_i;
  assign w_pop     = dev_rvalid_i & (r_count != '0);
  assign w_head    = r_ids[r_rptr];

  // Address phase: host 0 fields drive the bus whenever host 1 is not selected
  assign dev_req_o   = w_dev_req;
  assign dev_we_o    = w_sel ? h1_we_i    : h0_we_i;
  assign dev_addr_o  = w_sel ? h1_addr_i  : h0_addr_i;
  assign dev_be_o    = w_sel ? h1_be_i    : h0_be_i;
  assign dev_wdata_o = w_sel ? h1_wdata_i : h0_wdata_i;

  assign h0_gnt_o = w_push & ~w_sel;
  assign h1_gnt_o = w_push &  w_sel;

  // Response phase: only the host at the FIFO head sees rvalid/rdata/err
  assign h0_rvalid_o = w_pop & ~w_head;
  assign h1_rvalid_o = w_pop &  w_head;
  assign h0_rdata_o  = h0_rvalid_o ? dev_rdata_i : 32'h0;
  assign h1_rdata_o  = h1_rvalid_o ? dev_rdata_i : 32'h0;
  assign h0_err_o    = h0_rvalid_o & dev_err_i;
  assign h1_err_o    = h1_rvalid_o & dev_err_i;

  assign unexpected_rvalid_o = r_unexpected;

  // ID FIFO and outstanding count; simultaneous push and pop leave the count unchanged
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_count <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_ids   <= '0;
    end else begin
      if (w_push) begin
        r_ids[r_wptr] <= w_sel;
        r_wptr        <= ptr_inc(r_wptr);
      end
      if (w_pop) begin
        r_rptr <= ptr_inc(r_rptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky flag for a device response with nothing outstanding
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_unexpected <= 1'b0;
    end else if (dev_rvalid_i && (r_count == '0)) begin
      r_unexpected <= 1'b1;
    end
  end

endmodule

// File: tb/tb_simple_system_dmem_arb.sv
// tb/tb_simple_system_dmem_arb.sv - directed self-checking bench for simple_system_dmem_arb

module tb_simple_system_dmem_arb;

  logic        clk;
  logic        rst_n;
  logic        h0_req, h0_gnt, h0_we, h0_rvalid, h0_err;
  logic [31:0] h0_addr, h0_wdata, h0_rdata;
  logic [3:0]  h0_be;
  logic        h1_req, h1_gnt, h1_we, h1_rvalid, h1_err;
  logic [31:0] h1_addr, h1_wdata, h1_rdata;
  logic [3:0]  h1_be;
  logic        dev_req, dev_gnt, dev_we, dev_rvalid, dev_err, unexp;
  logic [31:0] dev_addr, dev_wdata, dev_rdata;
  logic [3:0]  dev_be;

  int checks = 0;
  int failures = 0;
  logic exp_g, prev_g;

  simple_system_dmem_arb #(.MaxOutstanding(2)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .h0_req_i(h0_req), .h0_gnt_o(h0_gnt), .h0_we_i(h0_we), .h0_addr_i(h0_addr),
    .h0_be_i(h0_be), .h0_wdata_i(h0_wdata), .h0_rvalid_o(h0_rvalid),
    .h0_rdata_o(h0_rdata), .h0_err_o(h0_err),
    .h1_req_i(h1_req), .h1_gnt_o(h1_gnt), .h1_we_i(h1_we), .h1_addr_i(h1_addr),
    .h1_be_i(h1_be), .h1_wdata_i(h1_wdata), .h1_rvalid_o(h1_rvalid),
    .h1_rdata_o(h1_rdata), .h1_err_o(h1_err),
    .dev_req_o(dev_req), .dev_gnt_i(dev_gnt), .dev_we_o(dev_we), .dev_addr_o(dev_addr),
    .dev_be_o(dev_be), .dev_wdata_o(dev_wdata), .dev_rvalid_i(dev_rvalid),
    .dev_rdata_i(dev_rdata), .dev_err_i(dev_err),
    .unexpected_rvalid_o(unexp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge and return all handshake inputs to idle
  task automatic next();
    @(posedge clk);
    #1;
    h0_req = 1'b0;
    h1_req = 1'b0;
    dev_gnt = 1'b0;
    dev_rvalid = 1'b0;
    dev_err = 1'b0;
    dev_rdata = 32'h0;
  endtask

  initial begin
    rst_n = 1'b0;
    h0_req = 0; h0_we = 0; h0_addr = 32'hA0; h0_be = 4'h3; h0_wdata = 32'h1111_0000;
    h1_req = 0; h1_we = 1; h1_addr = 32'hB0; h1_be = 4'hC; h1_wdata = 32'h2222_0000;
    dev_gnt = 0; dev_rvalid = 0; dev_err = 0; dev_rdata = 32'h0;

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    chk1("rst_dev_req", dev_req, 1'b0);
    chk1("rst_h0_gnt", h0_gnt, 1'b0);
    chk1("rst_h1_gnt", h1_gnt, 1'b0);
    chk1("rst_h0_rvalid", h0_rvalid, 1'b0);
    chk1("rst_h1_rvalid", h1_rvalid, 1'b0);
    chk32("rst_h0_rdata", h0_rdata, 32'h0);
    chk1("rst_unexp", unexp, 1'b0);
    chk32("rst_idle_addr", dev_addr, 32'hA0);
    rst_n = 1'b1;

    // Contention for 6 cycles, device latency 1
    prev_g = 1'b0;
    for (int i = 0; i < 6; i++) begin
      next();
      h0_req = 1; h1_req = 1; dev_gnt = 1;
      dev_rvalid = (i > 0);
      dev_rdata = 32'h2000 + i;
      #1;
`ifdef SIMPLE_SYSTEM_DMEM_ARB_RR_EN
      exp_g = i[0];
`else
      exp_g = 1'b0;
`endif
      chk1("cont_h0_gnt", h0_gnt, ~exp_g);
      chk1("cont_h1_gnt", h1_gnt, exp_g);
      chk32("cont_addr", dev_addr, exp_g ? 32'hB0 : 32'hA0);
      chk1("cont_we", dev_we, exp_g);
      chk32("cont_be", {28'h0, dev_be}, exp_g ? 32'hC : 32'h3);
      if (i > 0) begin
        chk1("cont_h0_rvalid", h0_rvalid, ~prev_g);
        chk1("cont_h1_rvalid", h1_rvalid, prev_g);
        chk32("cont_rdata", prev_g ? h1_rdata : h0_rdata, 32'h2000 + i);
      end
      prev_g = exp_g;
    end
    next();
    dev_rvalid = 1; dev_rdata = 32'h2006;
    #1;
    chk1("cont_last_h0_rvalid", h0_rvalid, ~prev_g);
    chk1("cont_last_h1_rvalid", h1_rvalid, prev_g);

    // Single host 0 read with rdata DEADBEEF
    next();
    h0_req = 1; h0_addr = 32'h100; dev_gnt = 1;
    #1;
    chk1("rd_dev_req", dev_req, 1'b1);
    chk1("rd_h0_gnt", h0_gnt, 1'b1);
    chk1("rd_h1_gnt", h1_gnt, 1'b0);
    chk32("rd_addr", dev_addr, 32'h100);
    next();
    dev_rvalid = 1; dev_rdata = 32'hDEAD_BEEF;
    #1;
    chk1("rd_h0_rvalid", h0_rvalid, 1'b1);
    chk32("rd_h0_rdata", h0_rdata, 32'hDEAD_BEEF);
    chk1("rd_h1_rvalid", h1_rvalid, 1'b0);
    chk32("rd_h1_rdata", h1_rdata, 32'h0);
    next();
    #1;
    chk32("rd_h0_rdata_idle", h0_rdata, 32'h0);

    // Fill to MaxOutstanding, then pop at full with a request pending
    next(); h0_req = 1; dev_gnt = 1; #1;
    chk1("full_g1", h0_gnt, 1'b1);
    next(); h0_req = 1; dev_gnt = 1; #1;
    chk1("full_g2", h0_gnt, 1'b1);
    next(); h0_req = 1; dev_gnt = 1; #1;
    chk1("full_dev_req", dev_req, 1'b0);
    chk1("full_h0_gnt", h0_gnt, 1'b0);
    next(); h0_req = 1; dev_gnt = 1; dev_rvalid = 1; dev_err = 1; #1;
    chk1("full_pop_dev_req", dev_req, 1'b0);
    chk1("full_pop_rvalid", h0_rvalid, 1'b1);
    chk1("full_pop_err", h0_err, 1'b1);
    chk1("full_pop_h1_err", h1_err, 1'b0);
    next(); h0_req = 1; dev_gnt = 1; #1;
    chk1("full_regrant", h0_gnt, 1'b1);
    next(); dev_rvalid = 1; #1;
    chk1("full_drain1", h0_rvalid, 1'b1);
    next(); dev_rvalid = 1; #1;
    chk1("full_drain2", h0_rvalid, 1'b1);

    // Five interleaved transactions, IDs 0,1,1,0,1, across pointer wraps
    next(); h0_req = 1; dev_gnt = 1; #1;
    chk1("wrap_g0", h0_gnt, 1'b1);
    next(); h1_req = 1; dev_gnt = 1; #1;
    chk1("wrap_g1", h1_gnt, 1'b1);
    next(); h1_req = 1; dev_gnt = 1; dev_rvalid = 1; #1;
    chk1("wrap_full_h1_gnt", h1_gnt, 1'b0);
    chk1("wrap_r0", h0_rvalid, 1'b1);
    next(); h1_req = 1; dev_gnt = 1; dev_rvalid = 1; #1;
    chk1("wrap_g2", h1_gnt, 1'b1);
    chk1("wrap_r1", h1_rvalid, 1'b1);
    next(); h0_req = 1; dev_gnt = 1; dev_rvalid = 1; #1;
    chk1("wrap_g3", h0_gnt, 1'b1);
    chk1("wrap_r2", h1_rvalid, 1'b1);
    next(); h1_req = 1; dev_gnt = 1; dev_rvalid = 1; #1;
    chk1("wrap_g4", h1_gnt, 1'b1);
    chk1("wrap_r3_h0", h0_rvalid, 1'b1);
    chk1("wrap_r3_h1", h1_rvalid, 1'b0);
    next(); dev_rvalid = 1; #1;
    chk1("wrap_r4_h1", h1_rvalid, 1'b1);
    chk1("wrap_r4_h0", h0_rvalid, 1'b0);

    // Response with nothing outstanding
    next(); dev_rvalid = 1; dev_rdata = 32'h5555; #1;
    chk1("unexp_h0_rvalid", h0_rvalid, 1'b0);
    chk1("unexp_h1_rvalid", h1_rvalid, 1'b0);
    chk1("unexp_not_yet", unexp, 1'b0);
    next(); #1;
    chk1("unexp_set", unexp, 1'b1);
    next(); next(); #1;
    chk1("unexp_held", unexp, 1'b1);

    // Reset with two transactions outstanding
    next(); h0_req = 1; dev_gnt = 1; #1;
    chk1("rst2_g1", h0_gnt, 1'b1);
    next(); h0_req = 1; dev_gnt = 1; #1;
    chk1("rst2_g2", h0_gnt, 1'b1);
    next();
    rst_n = 1'b0;
    dev_rvalid = 1;
    #1;
    chk1("rst2_unexp_clr", unexp, 1'b0);
    chk1("rst2_dev_req", dev_req, 1'b0);
    chk1("rst2_h0_rvalid", h0_rvalid, 1'b0);
    chk1("rst2_h1_rvalid", h1_rvalid, 1'b0);
    next();
    rst_n = 1'b1;
    h0_req = 1; dev_gnt = 1;
    #1;
    chk1("rst2_post_gnt", h0_gnt, 1'b1);
    next(); dev_rvalid = 1; #1;
    chk1("rst2_post_rvalid", h0_rvalid, 1'b1);
    next(); dev_rvalid = 1; #1;
    chk1("rst2_stale_no_rvalid", h0_rvalid, 1'b0);
    next(); #1;
    chk1("rst2_stale_unexp", unexp, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
